// File: rtl/exec_result_pipe_pkg.sv
// Shared definitions for the execution-result staging pipe: packed-record field
// offsets, legal latency range, unit ids and the internal stage record.
package exec_result_pipe_pkg;

  localparam int unsigned RES_DEPTH  = 7;
  localparam int unsigned RES_DATA_W = 128;
  localparam int unsigned RES_ADDR_W = 7;
  localparam int unsigned RES_LAT_W  = 4;
  localparam int unsigned RES_UNIT_W = 3;

  localparam int unsigned PK_DATA_LSB = 0;
  localparam int unsigned PK_UNIT_LSB = 128;
  localparam int unsigned PK_DST_LSB  = 131;
  localparam int unsigned PK_LAT_LSB  = 138;
  localparam int unsigned PK_WR_BIT   = 142;
  localparam int unsigned PACKED_W    = 143;

  localparam logic [RES_LAT_W-1:0] LAT_MIN = 4'd2;
  localparam logic [RES_LAT_W-1:0] LAT_MAX = 4'd7;

  typedef enum logic [RES_UNIT_W-1:0] {
    UNIT_NONE = 3'd0,
    UNIT_ALU  = 3'd1,
    UNIT_MUL  = 3'd2,
    UNIT_SHF  = 3'd3,
    UNIT_FPU  = 3'd4,
    UNIT_LSU  = 3'd5,
    UNIT_BRU  = 3'd6,
    UNIT_PERM = 3'd7
  } unit_e;

  // valid marks an issued entry even when it does not write a register
  typedef struct packed {
    logic                  valid;
    logic                  reg_wr;
    logic [RES_LAT_W-1:0]  lat;
    logic [RES_ADDR_W-1:0] dst;
    logic [RES_UNIT_W-1:0] unit;
    logic                  ready;
    logic [RES_DATA_W-1:0] data;
  } stage_t;

  localparam int unsigned STAGE_W = $bits(stage_t);

  function automatic logic lat_legal(input logic [RES_LAT_W-1:0] lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

  function automatic logic [PACKED_W-1:0] pack_stage(input stage_t s);
    logic [PACKED_W-1:0] p;
    p = '0;
    p[PK_DATA_LSB +: RES_DATA_W] = s.data;
    p[PK_UNIT_LSB +: RES_UNIT_W] = s.unit;
    p[PK_DST_LSB  +: RES_ADDR_W] = s.dst;
    p[PK_LAT_LSB  +: RES_LAT_W]  = s.lat;
    p[PK_WR_BIT]                 = s.reg_wr;
    return p;
  endfunction

endpackage

// File: rtl/exec_result_pipe_stage.sv
// One pipeline stage register: loads the previous stage, optionally merges a
// unit result (data + ready), and is forced to a bubble on kill.
module result_stage_reg
  import exec_result_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kill,
  input  logic                  capture,
  input  logic [RES_DATA_W-1:0] cap_data,
  input  logic [STAGE_W-1:0]    stage_in,
  output logic [STAGE_W-1:0]    stage_out
);

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stage_t'(stage_in);
    if (capture) begin
      stage_d.data  = cap_data;
      stage_d.ready = 1'b1;
    end
    if (kill) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_out = stage_q;

endmodule

// File: rtl/exec_result_pipe.sv
// Per-pipe execution-result staging: stage 1 is the RF stage, stage DEPTH
// commits to the register file; stages always shift, stall only gates issue.
module exec_result_pipe
  import exec_result_pipe_pkg::*;
#(
  parameter int unsigned DEPTH  = RES_DEPTH,
  parameter int unsigned DATA_W = RES_DATA_W,
  parameter int unsigned ADDR_W = RES_ADDR_W,
  parameter int unsigned LAT_W  = RES_LAT_W,
  parameter int unsigned UNIT_W = RES_UNIT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                iss_valid,
  input  logic                iss_reg_wr,
  input  logic [ADDR_W-1:0]   iss_reg_dst,
  input  logic [LAT_W-1:0]    iss_latency,
  input  logic [UNIT_W-1:0]   iss_unit,
  input  logic                res_valid,
  input  logic [2:0]          res_stage,
  input  logic [DATA_W-1:0]   res_data,
  output logic [ADDR_W-1:0]   RF_reg_dst,
  output logic                RF_reg_wr,
  output logic [LAT_W-1:0]    RF_latency,
  output logic [PACKED_W-1:0] packed_2stage,
  output logic [PACKED_W-1:0] packed_3stage,
  output logic [PACKED_W-1:0] packed_4stage,
  output logic [PACKED_W-1:0] packed_5stage,
  output logic [PACKED_W-1:0] packed_6stage,
  output logic [DEPTH-1:0]    fwd_ready,
  output logic                wb_en,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic                err
);

  stage_t             st      [DEPTH];
  logic [STAGE_W-1:0] st_vec  [DEPTH];
  logic [STAGE_W-1:0] in_vec  [DEPTH];
  logic [DEPTH-1:0]   kill_v;
  logic [DEPTH-1:0]   cap_v;
  logic [DEPTH-1:0]   res_hit;
  logic               iss_take;
  stage_t             iss_entry;
  logic               res_sel_valid;
  logic [LAT_W-1:0]   res_sel_lat;
  logic               err_d, err_q;

  // Stage 1 is fed by issue; flush kills the stage-1 entry on its way to
  // stage 2, which also discards any stage-1 capture since kill wins.
  always_comb begin
    iss_take         = iss_valid && !stall && !flush;
    iss_entry        = '0;
    iss_entry.valid  = 1'b1;
    iss_entry.reg_wr = iss_reg_wr && lat_legal(iss_latency);
    iss_entry.lat    = iss_latency;
    iss_entry.dst    = iss_reg_dst;
    iss_entry.unit   = iss_unit;

    res_hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      res_hit[i] = res_valid && (res_stage == 3'(i + 1)) && st[i].valid;
    end

    kill_v    = '0;
    kill_v[0] = !iss_take;
    kill_v[1] = flush;
    cap_v     = '0;
    in_vec[0] = iss_entry;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      in_vec[i] = st_vec[i-1];
      cap_v[i]  = res_hit[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    result_stage_reg u_stage (
      .clk       (clk),
      .rst       (reset),
      .kill      (kill_v[g]),
      .capture   (cap_v[g]),
      .cap_data  (res_data),
      .stage_in  (in_vec[g]),
      .stage_out (st_vec[g])
    );
    assign st[g]        = stage_t'(st_vec[g]);
    assign fwd_ready[g] = st[g].valid &&
                          (st[g].ready || (LAT_W'(g + 1) > st[g].lat));
  end

  always_comb begin
    res_sel_valid = 1'b0;
    res_sel_lat   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (res_stage == 3'(i + 1)) begin
        res_sel_valid = st[i].valid;
        res_sel_lat   = st[i].lat;
      end
    end

    err_d = err_q;
    if (res_valid && (res_stage == '0)) err_d = 1'b1;
    if (res_valid && (res_stage != '0) && !res_sel_valid) err_d = 1'b1;
    if (res_valid && res_sel_valid && (res_sel_lat != {1'b0, res_stage})) err_d = 1'b1;
    if (iss_take && !lat_legal(iss_latency)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign RF_reg_dst    = st[0].dst;
  assign RF_reg_wr     = st[0].reg_wr;
  assign RF_latency    = st[0].lat;
  assign packed_2stage = pack_stage(st[1]);
  assign packed_3stage = pack_stage(st[2]);
  assign packed_4stage = pack_stage(st[3]);
  assign packed_5stage = pack_stage(st[4]);
  assign packed_6stage = pack_stage(st[5]);
  assign wb_en         = st[DEPTH-1].reg_wr;
  assign wb_addr       = st[DEPTH-1].dst;
  assign wb_data       = res_hit[DEPTH-1] ? res_data : st[DEPTH-1].data;
  assign err           = err_q;

endmodule
